// File: rtl/carga_imagen_pkg.sv
// Shared video package: FSM encoding and X-Y address geometry of the image RAM.
// The display addressing logic uses the same row/col split.
package carga_imagen_pkg;

  localparam int ADDR_W = 17;
  localparam int ROW_W  = 8;
  localparam int COL_W  = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } estado_t;

endpackage

// File: rtl/carga_imagen_contador.sv
// Raster row/column counter for the frame loader; last flags the final pixel position.
// Clear wins over inc; the counter wraps to 0,0 after the last pixel so it never leaves the image.
module contador_xy
  import carga_imagen_pkg::*;
#(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

  assign last = (row == ROW_MAX) && (col == COL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (inc) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/carga_imagen.sv
// Frame-buffer writer: turns a raster pixel stream into {row,col}-addressed RAM writes.
// One-cycle write latency; pix_ready is high only while loading, so the source simply holds.
module carga_imagen
  import carga_imagen_pkg::*;
#(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  if (IMG_W < 1 || IMG_W > 512 || IMG_H < 1 || IMG_H > 256) begin : g_geom_chk
    $fatal(1, "carga_imagen: image geometry %0dx%0d exceeds the 512x256 address space", IMG_W, IMG_H);
  end

  estado_t          estado, estado_sig;
  logic             xfer, cnt_inc, cnt_clear, last;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

  assign xfer = pix_valid & pix_ready;

  contador_xy #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_contador (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .clear (cnt_clear),
    .row   (row),
    .col   (col),
    .last  (last)
  );

  // A restart in LOAD swallows any coincident pixel: it is consumed but never written.
  always_comb begin
    estado_sig = estado;
    cnt_inc    = 1'b0;
    cnt_clear  = 1'b0;
    case (estado)
      IDLE: begin
        if (start) begin
          estado_sig = LOAD;
          cnt_clear  = 1'b1;
        end
      end
      LOAD: begin
        if (start) begin
          cnt_clear = 1'b1;
        end else if (xfer) begin
          cnt_inc = 1'b1;
          if (last) estado_sig = DONE;
        end
      end
      DONE:    estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado    <= IDLE;
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      estado    <= estado_sig;
      pix_ready <= (estado_sig == LOAD);
      busy      <= (estado_sig != IDLE);
      done      <= (estado_sig == DONE);
      wr_en     <= cnt_inc;
      if (cnt_inc) begin
        wr_addr <= {row, col};
        wr_data <= pix_data;
      end
    end
  end

endmodule
